// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage, the instruction-memory port and decode.
// The master side is the fetch stage; the slave side is memory plus decode.
interface if_stage_if;
    logic [32:0] branch_data;
    logic        ds_allowin;
    logic        fs_valid;
    logic [63:0] fs_data;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        input  branch_data,
        input  ds_allowin,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata,
        output fs_valid,
        output fs_data,
        output inst_req,
        output inst_addr
    );

    modport slave (
        output branch_data,
        output ds_allowin,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata,
        input  fs_valid,
        input  fs_data,
        input  inst_req,
        input  inst_addr
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding word fetch, {pc, inst} output register
// plus a one-entry skid buffer, and taken-branch redirect with stale-response cancel.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
);

    typedef enum logic {S_REQ, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        cancel_q, cancel_d;
    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic [31:0] fs_inst_q, fs_inst_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;

    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_req;
    logic        addr_hs;
    logic        data_hs;
    logic        deliver;
    logic        ds_take;

    assign br_taken  = bus.branch_data[32];
    assign br_target = bus.branch_data[31:0] & ~32'h3;

    // Never request while the skid buffer is occupied: every response then has a slot.
    assign inst_req = (state_q == S_REQ) && !buf_valid_q && !rst;
    assign addr_hs  = inst_req && bus.inst_addr_ok;
    assign data_hs  = (state_q == S_RESP) && bus.inst_data_ok;
    assign deliver  = data_hs && !cancel_q && !br_taken;
    assign ds_take  = fs_valid_q && bus.ds_allowin;

    assign bus.inst_req  = inst_req;
    assign bus.inst_addr = fetch_pc_q;
    assign bus.fs_valid  = fs_valid_q;
    assign bus.fs_data   = {fs_pc_q, fs_inst_q};

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        cancel_d    = cancel_q;
        fs_valid_d  = fs_valid_q;
        fs_pc_d     = fs_pc_q;
        fs_inst_d   = fs_inst_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;

        case (state_q)
            S_REQ: begin
                if (addr_hs) begin
                    state_d    = S_RESP;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            S_RESP: begin
                if (bus.inst_data_ok) begin
                    state_d  = S_REQ;
                    cancel_d = 1'b0;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (ds_take) begin
            if (buf_valid_q) begin
                fs_pc_d     = buf_pc_q;
                fs_inst_d   = buf_inst_q;
                buf_valid_d = 1'b0;
            end else begin
                fs_valid_d  = 1'b0;
            end
        end

        if (deliver) begin
            if (!fs_valid_q || bus.ds_allowin) begin
                fs_valid_d = 1'b1;
                fs_pc_d    = req_pc_q;
                fs_inst_d  = bus.inst_rdata;
            end else begin
                buf_valid_d = 1'b1;
                buf_pc_d    = req_pc_q;
                buf_inst_d  = bus.inst_rdata;
            end
        end

        // Redirect wins: flush both slots and mark any in-flight response as stale.
        if (br_taken) begin
            fetch_pc_d  = br_target;
            fs_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
            if (state_q == S_REQ) begin
                if (addr_hs) begin
                    cancel_d = 1'b1;
                end
            end else begin
                cancel_d = !bus.inst_data_ok;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= 32'd0;
            cancel_q    <= 1'b0;
            fs_valid_q  <= 1'b0;
            fs_pc_q     <= 32'd0;
            fs_inst_q   <= 32'd0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'd0;
            buf_inst_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            cancel_q    <= cancel_d;
            fs_valid_q  <= fs_valid_d;
            fs_pc_q     <= fs_pc_d;
            fs_inst_q   <= fs_inst_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
        end
    end

endmodule
